// File: rtl/trade_order_sequencer.sv
// trade_order_sequencer: turns crossover pulses into single valid/ready orders with fill wait, position limit and cooldown.
// Optional ORDER_STATS_EN adds saturating fill/reject/timeout counters.
module trade_order_sequencer #(
  parameter int MAX_POS      = 4,
  parameter int ORDER_QTY    = 1,
  parameter int FILL_TIMEOUT = 16,
  parameter int COOLDOWN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] price_in,
  output logic       order_valid,
  input  logic       order_ready,
  output logic       order_side,
  output logic [7:0] order_price,
  output logic [7:0] order_qty,
  input  logic       fill_valid,
  input  logic       fill_ok,
  output logic [7:0] position,
  output logic       busy,
  output logic       timeout_err
`ifdef ORDER_STATS_EN
  ,
  output logic [15:0] fill_count,
  output logic [15:0] reject_count,
  output logic [15:0] timeout_count
`endif
);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam logic signed [7:0] QTY = 8'(ORDER_QTY);
  localparam logic signed [8:0] Q9 = 9'(ORDER_QTY);
  localparam logic signed [8:0] M9 = 9'(MAX_POS);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COOL} state_t;
  state_t state_q, state_d;
  logic side_q, side_d, valid_q, valid_d, busy_q, busy_d, terr_q, terr_d, done;
  logic [7:0] price_q, price_d, qty_q, qty_d;
  logic signed [7:0] pos_q, pos_d;
  logic signed [8:0] pos9;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cd_q, cd_d;
  logic buy_ok, sell_ok;
  assign pos9 = pos_q;
  assign buy_ok = buy_signal & ~sell_signal & (pos9 + Q9 <= M9);
  assign sell_ok = sell_signal & ~buy_signal & (pos9 - Q9 >= -M9);
  always_comb begin
    state_d = state_q;
    side_d = side_q;
    price_d = price_q;
    pos_d = pos_q;
    tmr_d = tmr_q;
    cd_d = cd_q;
    terr_d = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE: if (buy_ok || sell_ok) begin
        state_d = S_ISSUE;
        side_d = buy_ok;
        price_d = price_in;
      end
      S_ISSUE: if (order_ready) begin
        state_d = S_WAIT;
        tmr_d = '0;
      end
      S_WAIT: begin
        // a fill arriving on the timeout edge takes precedence over the timeout
        if (fill_valid) begin
          done = 1'b1;
          pos_d = fill_ok ? (side_q ? pos_q + QTY : pos_q - QTY) : pos_q;
        end else if (tmr_q == TW'(FILL_TIMEOUT - 1)) begin
          done = 1'b1;
          terr_d = 1'b1;
        end else tmr_d = tmr_q + 1'b1;
      end
      S_COOL: if (cd_q == CW'(COOLDOWN - 1)) state_d = S_IDLE; else cd_d = cd_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d = (COOLDOWN == 0) ? S_IDLE : S_COOL;
      cd_d = '0;
    end
    valid_d = state_d == S_ISSUE;
    busy_d = state_d != S_IDLE;
    qty_d = valid_d ? QTY : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      side_q <= 1'b0;
      price_q <= '0;
      pos_q <= '0;
      tmr_q <= '0;
      cd_q <= '0;
      terr_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      qty_q <= '0;
    end else begin
      state_q <= state_d;
      side_q <= side_d;
      price_q <= price_d;
      pos_q <= pos_d;
      tmr_q <= tmr_d;
      cd_q <= cd_d;
      terr_q <= terr_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      qty_q <= qty_d;
    end
  end
  assign order_valid = valid_q;
  assign order_side = side_q;
  assign order_price = price_q;
  assign order_qty = qty_q;
  assign position = pos_q;
  assign busy = busy_q;
  assign timeout_err = terr_q;
`ifdef ORDER_STATS_EN
  logic [15:0] fc_q, fc_d, rc_q, rc_d, tc_q, tc_d;
  logic resp;
  always_comb begin
    resp = state_q == S_WAIT && fill_valid;
    fc_d = (resp && fill_ok && fc_q != 16'hFFFF) ? fc_q + 1'b1 : fc_q;
    rc_d = (resp && !fill_ok && rc_q != 16'hFFFF) ? rc_q + 1'b1 : rc_q;
    tc_d = (terr_d && tc_q != 16'hFFFF) ? tc_q + 1'b1 : tc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q <= '0;
      rc_q <= '0;
      tc_q <= '0;
    end else begin
      fc_q <= fc_d;
      rc_q <= rc_d;
      tc_q <= tc_d;
    end
  end
  assign fill_count = fc_q;
  assign reject_count = rc_q;
  assign timeout_count = tc_q;
`endif
endmodule

// File: tb/tb_trade_order_sequencer.sv
// tb_trade_order_sequencer: directed stimulus with an order scoreboard checked on each handshake.
module tb_trade_order_sequencer;
  logic clk = 1'b0, rst = 1'b1, buy_signal = 1'b0, sell_signal = 1'b0;
  logic [7:0] price_in = 8'd0;
  logic order_valid, order_ready = 1'b0, order_side, fill_valid = 1'b0, fill_ok = 1'b0, busy, timeout_err;
  logic [7:0] order_price, order_qty, position;
`ifdef ORDER_STATS_EN
  logic [15:0] fill_count, reject_count, timeout_count;
`endif
  int n_chk = 0, n_fail = 0, exp_pos = 0;
  logic [16:0] exp_q[$];
  trade_order_sequencer dut (
    .clk(clk), .rst(rst), .buy_signal(buy_signal), .sell_signal(sell_signal), .price_in(price_in),
    .order_valid(order_valid), .order_ready(order_ready), .order_side(order_side),
    .order_price(order_price), .order_qty(order_qty), .fill_valid(fill_valid), .fill_ok(fill_ok),
    .position(position), .busy(busy), .timeout_err(timeout_err)
`ifdef ORDER_STATS_EN
    , .fill_count(fill_count), .reject_count(reject_count), .timeout_count(timeout_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  always @(posedge clk) if (!rst && order_valid && order_ready) begin
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL order_unexpected: got side=%0d price=%0d qty=%0d expected none", order_side, order_price, order_qty);
    end else begin
      logic [16:0] e;
      e = exp_q.pop_front();
      if ({order_side, order_price, order_qty} != e) begin
        n_fail++;
        $display("FAIL order_fields: got side=%0d price=%0d qty=%0d expected side=%0d price=%0d qty=%0d",
                 order_side, order_price, order_qty, e[16], e[15:8], e[7:0]);
      end
    end
  end
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk("idle_within_bound", int'(busy), 0);
  endtask
  task automatic accept(input logic side, input logic [7:0] p);
    order_ready = 1'b1;
    price_in = p;
    buy_signal = side;
    sell_signal = ~side;
    exp_q.push_back({side, p, 8'd1});
    tick();
    buy_signal = 1'b0;
    sell_signal = 1'b0;
    chk("issue_valid", int'(order_valid), 1);
    tick();
    chk("transfer_valid_low", int'(order_valid), 0);
  endtask
  task automatic order(input logic side, input logic [7:0] p, input logic ok);
    accept(side, p);
    fill_valid = 1'b1;
    fill_ok = ok;
    tick();
    fill_valid = 1'b0;
    if (ok) exp_pos += side ? 1 : -1;
    chk("position_after_fill", int'($signed(position)), exp_pos);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(2);
    chk("rst_valid", int'(order_valid), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qty", int'(order_qty), 0);
    chk("rst_price", int'(order_price), 0);
    chk("rst_terr", int'(timeout_err), 0);
    rst = 1'b0;
    tick();
    // test 1: buy, fill, exact 8-cycle cooldown
    accept(1'b1, 8'd100);
    fill_valid = 1'b1;
    fill_ok = 1'b1;
    tick();
    fill_valid = 1'b0;
    exp_pos = 1;
    chk("t1_position", int'($signed(position)), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_cooldown_busy", int'(busy), 1);
      tick();
    end
    chk("t1_idle_after_cooldown", int'(busy), 0);
    // test 2: backpressure with ramping price
    order_ready = 1'b0;
    price_in = 8'd100;
    buy_signal = 1'b1;
    exp_q.push_back({1'b1, 8'd100, 8'd1});
    tick();
    buy_signal = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      price_in = 8'(100 + i);
      chk("t2_hold_valid", int'(order_valid), 1);
      chk("t2_hold_price", int'(order_price), 100);
      tick();
    end
    order_ready = 1'b1;
    tick();
    chk("t2_transfer", int'(order_valid), 0);
    fill_valid = 1'b1;
    fill_ok = 1'b1;
    tick();
    fill_valid = 1'b0;
    exp_pos = 2;
    chk("t2_position", int'($signed(position)), 2);
    wait_idle();
    // test 3: position limit
    order(1'b1, 8'd110, 1'b1);
    wait_idle();
    order(1'b1, 8'd111, 1'b1);
    wait_idle();
    chk("t3_at_limit", int'($signed(position)), 4);
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    chk("t3_limit_no_valid", int'(order_valid), 0);
    chk("t3_limit_not_busy", int'(busy), 0);
    order(1'b0, 8'd90, 1'b1);
    wait_idle();
    chk("t3_after_sell", int'($signed(position)), 3);
    // test 4: fill timeout on the 16th WAIT_FILL cycle
    accept(1'b1, 8'd120);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_no_early_timeout", int'(timeout_err), 0);
    end
    tick();
    chk("t4_timeout_pulse", int'(timeout_err), 1);
    chk("t4_position_kept", int'($signed(position)), 3);
    tick();
    chk("t4_pulse_one_cycle", int'(timeout_err), 0);
`ifdef ORDER_STATS_EN
    chk("t4_timeout_count", int'(timeout_count), 1);
`endif
    wait_idle();
    // test 5: conflicts and ignored inputs
    buy_signal = 1'b1;
    sell_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    sell_signal = 1'b0;
    chk("t5_both_no_valid", int'(order_valid), 0);
    chk("t5_both_not_busy", int'(busy), 0);
    order(1'b1, 8'd130, 1'b0);
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    wait_idle();
    tick();
    chk("t5_cooldown_drop", int'(order_valid), 0);
    fill_valid = 1'b1;
    fill_ok = 1'b1;
    tick();
    fill_valid = 1'b0;
    chk("t5_idle_fill_ignored", int'($signed(position)), 3);
    accept(1'b0, 8'd140);
    tick(15);
    fill_valid = 1'b1;
    fill_ok = 1'b1;
    tick();
    fill_valid = 1'b0;
    chk("t5_fill_beats_timeout_terr", int'(timeout_err), 0);
    chk("t5_fill_beats_timeout_pos", int'($signed(position)), 2);
    wait_idle();
    // test 6: reset during WAIT_FILL
    accept(1'b1, 8'd150);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_position", int'(position), 0);
    chk("t6_valid", int'(order_valid), 0);
    fill_valid = 1'b1;
    fill_ok = 1'b1;
    tick();
    fill_valid = 1'b0;
    chk("t6_late_fill_position", int'(position), 0);
    chk("t6_late_fill_busy", int'(busy), 0);
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
